// File: rtl/vga_rd_pkg.sv
// Shared types for the VGA framebuffer read scheduler.
// Holds the FSM state encoding and the counter/burst-length widths used by
// the scheduler top and its address generator.
package vga_rd_pkg;

   // Remaining-word counter width; must hold LINE_PIX*FRAME_LINES.
   localparam int CNT_W = 20;
   // Burst length width; holds lengths 0..256.
   localparam int LEN_W = 9;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_VS = 3'd1,
      FLUSH   = 3'd2,
      CHECK   = 3'd3,
      REQ     = 3'd4,
      DATA    = 3'd5,
      DONE    = 3'd6
   } state_t;

endpackage

// File: rtl/vga_rd_addr_gen.sv
// Purpose : framebuffer address / remaining-word tracker with burst sizing.
// Latency : load, latch and step take effect on the next sclk edge.
// Backpres: none; strobes come from the scheduler FSM, which owns flow control.
// Ports   : sclk/s_rst clock and sync reset; load restarts at base with a full
//           frame; latch captures min(BURST_LEN, remain) into len; step advances
//           addr and consumes remain by len; addr/remain/len/remain_zero state.
module vga_rd_addr_gen
   import vga_rd_pkg::*;
#(
   parameter int                ADDR_W    = 24,
   parameter int                BURST_LEN = 8,
   parameter int                TOTAL     = 384000,
   parameter logic [ADDR_W-1:0] RST_ADDR  = '0
) (
   input  logic              sclk,
   input  logic              s_rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] base,
   input  logic              latch,
   input  logic              step,
   output logic [ADDR_W-1:0] addr,
   output logic [CNT_W-1:0]  remain,
   output logic [LEN_W-1:0]  len,
   output logic              remain_zero
);

   localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);

   logic [LEN_W-1:0] next_len;

   // Tail of the frame may be shorter than a full burst.
   always_comb begin
      next_len = LEN_W'(BURST_LEN);
      if (remain < BURST_C) begin
         next_len = remain[LEN_W-1:0];
      end
   end

   assign remain_zero = (remain == '0);

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         addr   <= RST_ADDR;
         remain <= '0;
         len    <= '0;
      end else if (load) begin
         addr   <= base;
         remain <= TOTAL_C;
      end else begin
         if (latch) begin
            len <= next_len;
         end
         if (step) begin
            // Wraps modulo 2^ADDR_W by construction.
            addr   <= addr + ADDR_W'(len);
            remain <= remain - CNT_W'(len);
         end
      end
   end

endmodule

// File: rtl/vga_rd_sched.sv
// Purpose : per-frame SDRAM burst read scheduler feeding the VGA pixel FIFO.
// Latency : vsync edge seen 1 cycle late; request 1 cycle after CHECK sees low level.
// Backpres: rd_req held with stable addr/len until rd_ack; refills only below FIFO_LOW.
// Ports   : sclk, s_rst (sync, active high); rd_en enable; vga_vsync; fifo_lvl;
//           fifo_clr flush pulse; rd_req/rd_ack/rd_addr/rd_len request handshake;
//           rd_vld returned-word strobe; frame_done, frame_err pulses; busy.
// Option  : define VGA_RD_DOUBLE_BUF_EN to add FB_BASE2, wr_buf_done, rd_buf_sel.
module vga_rd_sched
   import vga_rd_pkg::*;
#(
   parameter int                ADDR_W      = 24,
   parameter int                LVL_W       = 10,
   parameter logic [ADDR_W-1:0] FB_BASE     = 24'h000000,
`ifdef VGA_RD_DOUBLE_BUF_EN
   parameter logic [ADDR_W-1:0] FB_BASE2    = 24'h080000,
`endif
   parameter int                LINE_PIX    = 800,
   parameter int                FRAME_LINES = 480,
   parameter int                BURST_LEN   = 8,
   parameter int                FIFO_DEPTH  = 512,
   parameter int                FIFO_LOW    = 256
) (
   input  logic              sclk,
   input  logic              s_rst,
   input  logic              rd_en,
   input  logic              vga_vsync,
   input  logic [LVL_W-1:0]  fifo_lvl,
`ifdef VGA_RD_DOUBLE_BUF_EN
   input  logic              wr_buf_done,
   output logic              rd_buf_sel,
`endif
   output logic              fifo_clr,
   output logic              rd_req,
   input  logic              rd_ack,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [LEN_W-1:0]  rd_len,
   input  logic              rd_vld,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   localparam int TOTAL = LINE_PIX * FRAME_LINES;

   if (FIFO_LOW + BURST_LEN > FIFO_DEPTH) begin : g_bad_cfg
      $error("vga_rd_sched: FIFO_LOW + BURST_LEN exceeds FIFO_DEPTH");
   end

   state_t            state, state_nxt;
   logic              vs_d, vs_rise;
   logic              restart, stop;
   logic [LEN_W-1:0]  wcnt;
   logic              burst_end, lvl_low;
   logic              load, latch, step;
   logic [ADDR_W-1:0] addr, base;
   logic [CNT_W-1:0]  remain;
   logic [LEN_W-1:0]  len;
   logic              remain_zero;

   assign vs_rise   = vga_vsync & ~vs_d;
   assign lvl_low   = fifo_lvl < LVL_W'(FIFO_LOW);
   assign burst_end = (state == DATA) && rd_vld && (LEN_W'(wcnt + 1'b1) == len);

`ifdef VGA_RD_DOUBLE_BUF_EN
   logic buf_sel, buf_pend;

   // base is only consumed in FLUSH, where it must reflect the post-toggle select.
   assign base       = (buf_sel ^ buf_pend) ? FB_BASE2 : FB_BASE;
   assign rd_buf_sel = buf_sel;

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         buf_sel  <= 1'b0;
         buf_pend <= 1'b0;
      end else if (state == FLUSH) begin
         buf_sel  <= buf_sel ^ buf_pend;
         buf_pend <= wr_buf_done;   // a swap arriving now belongs to the next frame
      end else if (wr_buf_done) begin
         buf_pend <= 1'b1;
      end
   end
`else
   assign base = FB_BASE;
`endif

   vga_rd_addr_gen #(
      .ADDR_W    (ADDR_W),
      .BURST_LEN (BURST_LEN),
      .TOTAL     (TOTAL),
      .RST_ADDR  (FB_BASE)
   ) u_addr_gen (
      .sclk        (sclk),
      .s_rst       (s_rst),
      .load        (load),
      .base        (base),
      .latch       (latch),
      .step        (step),
      .addr        (addr),
      .remain      (remain),
      .len         (len),
      .remain_zero (remain_zero)
   );

   always_ff @(posedge sclk) begin
      if (s_rst) begin
         state   <= IDLE;
         vs_d    <= 1'b0;
         wcnt    <= '0;
         restart <= 1'b0;
         stop    <= 1'b0;
      end else begin
         state <= state_nxt;
         vs_d  <= vga_vsync;
         if (state != DATA) begin
            wcnt <= '0;
         end else if (rd_vld) begin
            wcnt <= wcnt + 1'b1;
         end
         // restart: a vsync landed while a burst was in flight (or exactly as
         // the frame completed); the burst drains, then the frame restarts.
         if (state == FLUSH || state == IDLE) begin
            restart <= 1'b0;
         end else if (vs_rise && (state == REQ || state == DATA ||
                                  (state == CHECK && remain_zero))) begin
            restart <= 1'b1;
         end
         // stop: rd_en dropped mid-burst; honoured once the burst drains.
         if (state == FLUSH || state == IDLE) begin
            stop <= 1'b0;
         end else if (!rd_en && (state == REQ || state == DATA)) begin
            stop <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      latch     = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE:    if (rd_en) state_nxt = WAIT_VS;
         WAIT_VS: begin
            if (!rd_en)       state_nxt = IDLE;
            else if (vs_rise) state_nxt = FLUSH;
         end
         FLUSH: begin
            load      = 1'b1;
            state_nxt = CHECK;
         end
         CHECK: begin
            if (!rd_en)           state_nxt = IDLE;
            else if (remain_zero) state_nxt = DONE;
            else if (vs_rise)     state_nxt = FLUSH;
            else if (lvl_low) begin
               latch     = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ:     if (rd_ack) state_nxt = DATA;
         DATA: begin
            if (burst_end) begin
               step = 1'b1;
               if (stop || !rd_en)         state_nxt = IDLE;
               else if (restart || vs_rise) state_nxt = FLUSH;
               else                         state_nxt = CHECK;
            end
         end
         DONE: begin
            if (restart || vs_rise) state_nxt = FLUSH;
            else                    state_nxt = WAIT_VS;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign fifo_clr   = (state == FLUSH);
   assign rd_req     = (state == REQ);
   assign rd_addr    = rd_req ? addr : '0;
   assign rd_len     = rd_req ? len : '0;
   assign frame_done = (state == DONE);
   assign frame_err  = vs_rise && ((state == CHECK && rd_en && !remain_zero) ||
                                   state == REQ || state == DATA);
   assign busy       = (state != IDLE) && (state != WAIT_VS);

endmodule

// File: tb/tb_vga_rd_sched.sv
`timescale 1ns/1ps
module tb_vga_rd_sched;

   localparam int EV_CLR  = 0;
   localparam int EV_ERR  = 1;
   localparam int EV_REQ  = 2;
   localparam int EV_DONE = 3;
   localparam int BASE2   = 32'h080000;

   typedef struct {
      int kind;
      int addr;
      int len;
   } ev_t;

   ev_t qa[$];
   ev_t qb[$];
   int  vectors     = 0;
   int  miscompares = 0;
   bit  in_burst_a  = 1'b0;

   logic sclk = 1'b0;
   always #5 sclk = ~sclk;
   logic s_rst;

   // Instance A: 16x2 frame. Instance B: 20x1 frame (partial final burst).
   logic        a_rd_en, a_vsync, a_rd_ack, a_rd_vld;
   logic [9:0]  a_lvl;
   logic        a_clr, a_req, a_done, a_err, a_busy;
   logic [23:0] a_addr;
   logic [8:0]  a_len;
   logic        b_rd_en, b_vsync, b_rd_ack, b_rd_vld;
   logic [9:0]  b_lvl;
   logic        b_clr, b_req, b_done, b_err, b_busy;
   logic [23:0] b_addr;
   logic [8:0]  b_len;
`ifdef VGA_RD_DOUBLE_BUF_EN
   logic a_wbd, a_bsel, b_wbd, b_bsel;
`endif

   vga_rd_sched #(.LINE_PIX(16), .FRAME_LINES(2), .BURST_LEN(8), .FIFO_LOW(4)) dut_a (
      .sclk(sclk), .s_rst(s_rst), .rd_en(a_rd_en), .vga_vsync(a_vsync), .fifo_lvl(a_lvl),
`ifdef VGA_RD_DOUBLE_BUF_EN
      .wr_buf_done(a_wbd), .rd_buf_sel(a_bsel),
`endif
      .fifo_clr(a_clr), .rd_req(a_req), .rd_ack(a_rd_ack), .rd_addr(a_addr), .rd_len(a_len),
      .rd_vld(a_rd_vld), .frame_done(a_done), .frame_err(a_err), .busy(a_busy));

   vga_rd_sched #(.LINE_PIX(20), .FRAME_LINES(1), .BURST_LEN(8), .FIFO_LOW(4)) dut_b (
      .sclk(sclk), .s_rst(s_rst), .rd_en(b_rd_en), .vga_vsync(b_vsync), .fifo_lvl(b_lvl),
`ifdef VGA_RD_DOUBLE_BUF_EN
      .wr_buf_done(b_wbd), .rd_buf_sel(b_bsel),
`endif
      .fifo_clr(b_clr), .rd_req(b_req), .rd_ack(b_rd_ack), .rd_addr(b_addr), .rd_len(b_len),
      .rd_vld(b_rd_vld), .frame_done(b_done), .frame_err(b_err), .busy(b_busy));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int sel, input int kind, input int addr, input int len);
      ev_t e;
      e.kind = kind; e.addr = addr; e.len = len;
      if (sel == 0) qa.push_back(e); else qb.push_back(e);
   endtask

   task automatic pop(input int sel, input int kind, input int addr, input int len);
      ev_t e;
      if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_event inst%0d: got kind %0d addr 0x%0h, expected none at %0t",
                  sel, kind, addr, $time);
      end else begin
         e = (sel == 0) ? qa.pop_front() : qb.pop_front();
         chk($sformatf("event_kind_inst%0d", sel), kind, e.kind);
         if (kind == EV_REQ && e.kind == EV_REQ) begin
            chk($sformatf("req_addr_inst%0d", sel), addr, e.addr);
            chk($sformatf("req_len_inst%0d", sel), len, e.len);
         end
      end
   endtask

   // Monitor: samples on the falling edge, pops the expected event per output.
   always @(negedge sclk) begin
      if (!s_rst) begin
         if (a_clr) begin
            pop(0, EV_CLR, 0, 0);
            chk("clr_outside_burst", 32'(in_burst_a), 0);
         end
         if (a_err)            pop(0, EV_ERR, 0, 0);
         if (a_req && a_rd_ack) pop(0, EV_REQ, 32'(a_addr), 32'(a_len));
         if (a_done)           pop(0, EV_DONE, 0, 0);
         if (b_clr)            pop(1, EV_CLR, 0, 0);
         if (b_err)            pop(1, EV_ERR, 0, 0);
         if (b_req && b_rd_ack) pop(1, EV_REQ, 32'(b_addr), 32'(b_len));
         if (b_done)           pop(1, EV_DONE, 0, 0);
      end
   end

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic set_ack(input int sel, input logic v);
      if (sel == 0) a_rd_ack = v; else b_rd_ack = v;
   endtask

   task automatic set_vld(input int sel, input logic v);
      if (sel == 0) a_rd_vld = v; else b_rd_vld = v;
   endtask

   task automatic set_vs(input int sel, input logic v);
      if (sel == 0) a_vsync = v; else b_vsync = v;
   endtask

   task automatic vs_pulse(input int sel);
      set_vs(sel, 1'b1);
      repeat (3) tick();
      set_vs(sel, 1'b0);
      tick();
   endtask

   // Arbiter model: wait for a request, ack after dly cycles, return nw words.
   // vs_at >= 0 raises vsync together with that word index.
   task automatic serve(input int sel, input int dly, input int nw, input int vs_at);
      int t = 0;
      while (((sel == 0) ? a_req : b_req) !== 1'b1 && t < 300) begin
         tick();
         t++;
      end
      chk($sformatf("req_within_budget_inst%0d", sel), 32'(t < 300), 1);
      if (t >= 300) return;
      repeat (dly) tick();
      set_ack(sel, 1'b1);
      tick();
      set_ack(sel, 1'b0);
      if (sel == 0) in_burst_a = 1'b1;
      for (int i = 0; i < nw; i++) begin
         if (i == vs_at) set_vs(sel, 1'b1);
         set_vld(sel, 1'b1);
         tick();
      end
      set_vld(sel, 1'b0);
      if (sel == 0) in_burst_a = 1'b0;
   endtask

   // One full 32-word frame on instance A starting at base.
   task automatic frame_a(input int base);
      push(0, EV_CLR, 0, 0);
      for (int k = 0; k < 4; k++) push(0, EV_REQ, base + 8 * k, 8);
      push(0, EV_DONE, 0, 0);
      vs_pulse(0);
      for (int k = 0; k < 4; k++) serve(0, 2, 8, -1);
      repeat (4) tick();
      chk("frame_a_idle_after_done", 32'(a_busy), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      s_rst = 1'b1;
      a_rd_en = 0; a_vsync = 0; a_rd_ack = 0; a_rd_vld = 0; a_lvl = '0;
      b_rd_en = 0; b_vsync = 0; b_rd_ack = 0; b_rd_vld = 0; b_lvl = '0;
`ifdef VGA_RD_DOUBLE_BUF_EN
      a_wbd = 0; b_wbd = 0;
`endif
      repeat (3) tick();
      chk("rst_fifo_clr", 32'(a_clr), 0);
      chk("rst_rd_req", 32'(a_req), 0);
      chk("rst_rd_addr", 32'(a_addr), 0);
      chk("rst_rd_len", 32'(a_len), 0);
      chk("rst_frame_done", 32'(a_done), 0);
      chk("rst_frame_err", 32'(a_err), 0);
      chk("rst_busy", 32'(a_busy), 0);
      s_rst = 1'b0;
      tick();

      // Partial final burst: 20 words -> 8, 8, 4.
      b_rd_en = 1'b1;
      repeat (2) tick();
      push(1, EV_CLR, 0, 0);
      push(1, EV_REQ, 0, 8);
      push(1, EV_REQ, 8, 8);
      push(1, EV_REQ, 16, 4);
      push(1, EV_DONE, 0, 0);
      vs_pulse(1);
      serve(1, 1, 8, -1);
      serve(1, 1, 8, -1);
      serve(1, 1, 4, -1);
      repeat (4) tick();
      chk("partial_idle_after_done", 32'(b_busy), 0);

      // Nominal frame.
      a_rd_en = 1'b1;
      repeat (2) tick();
      chk("wait_vs_not_busy", 32'(a_busy), 0);
      frame_a(0);

      // Threshold gating: level at FIFO_LOW holds off requests.
      a_lvl = 10'd4;
      push(0, EV_CLR, 0, 0);
      vs_pulse(0);
      for (int i = 0; i < 8; i++) begin
         chk("gated_no_req", 32'(a_req), 0);
         tick();
      end
      chk("gated_busy", 32'(a_busy), 1);
      a_lvl = 10'd3;
      tick();
      chk("req_after_level_drop", 32'(a_req), 1);

      // Early vsync during the second burst's data phase.
      push(0, EV_REQ, 0, 8);
      serve(0, 2, 8, -1);
      push(0, EV_REQ, 8, 8);
      push(0, EV_ERR, 0, 0);
      push(0, EV_CLR, 0, 0);
      for (int k = 0; k < 4; k++) push(0, EV_REQ, 8 * k, 8);
      push(0, EV_DONE, 0, 0);
      serve(0, 2, 8, 3);
      set_vs(0, 1'b0);
      for (int k = 0; k < 4; k++) serve(0, 2, 8, -1);
      repeat (4) tick();
      chk("restart_frame_idle", 32'(a_busy), 0);

      // Request hold with rd_en dropped: burst completes, then IDLE.
      push(0, EV_CLR, 0, 0);
      push(0, EV_REQ, 0, 8);
      vs_pulse(0);
      t = 0;
      while (a_req !== 1'b1 && t < 50) begin
         tick();
         t++;
      end
      chk("hold_req_seen", 32'(t < 50), 1);
      a_rd_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("hold_rd_req", 32'(a_req), 1);
         chk("hold_rd_addr", 32'(a_addr), 0);
         chk("hold_rd_len", 32'(a_len), 8);
         tick();
      end
      serve(0, 0, 8, -1);
      repeat (2) tick();
      chk("disabled_busy", 32'(a_busy), 0);
      chk("disabled_rd_req", 32'(a_req), 0);
      vs_pulse(0);
      repeat (4) tick();
      chk("disabled_ignores_vsync", 32'(a_busy), 0);

`ifdef VGA_RD_DOUBLE_BUF_EN
      // Buffer swap takes effect at the next frame start and persists.
      a_rd_en = 1'b1;
      a_lvl = '0;
      repeat (2) tick();
      a_wbd = 1'b1;
      tick();
      a_wbd = 1'b0;
      frame_a(BASE2);
      chk("dbuf_sel_after_swap", 32'(a_bsel), 1);
      frame_a(BASE2);
      chk("dbuf_sel_no_swap", 32'(a_bsel), 1);
`endif

      repeat (4) tick();
      chk("inst_a_events_drained", qa.size(), 0);
      chk("inst_b_events_drained", qb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vga_rd_sched.md
Name: vga_rd_sched

Overview:
- Read scheduler between the SDRAM read port and the VGA pixel FIFO that feeds the display driver's img_data.
- Each frame, starting on the vsync rising edge, it issues burst read requests over a linear framebuffer whenever FIFO occupancy falls below a threshold.
- It tracks address and remaining words, and flushes the FIFO at each frame start.
- Sequencing only; it carries no pixel data.

Parameters:
- FB_BASE, 24'h000000, framebuffer start word address
- LINE_PIX, 800, pixels (words) per line
- FRAME_LINES, 480, lines per frame
- BURST_LEN, 8, words per SDRAM read burst (power of 2, ≤ 256)
- FIFO_DEPTH, 512, pixel FIFO depth in words
- FIFO_LOW, 256, refill threshold; must satisfy FIFO_LOW + BURST_LEN ≤ FIFO_DEPTH
- ADDR_W, 24, SDRAM word address width
- LVL_W, 10, FIFO level width

Ports:
- sclk  in  1  system clock
- s_rst  in  1  synchronous active-high reset
- rd_en  in  1  scheduler enable
- vga_vsync  in  1  display vsync, high during sync
- fifo_lvl  in  LVL_W  pixel FIFO write-side occupancy
- fifo_clr  out  1  one-cycle FIFO flush
- rd_req  out  1  burst read request
- rd_ack  in  1  one-cycle acceptance from SDRAM arbiter
- rd_addr  out  ADDR_W  burst start address, valid while rd_req
- rd_len  out  9  burst length, valid while rd_req
- rd_vld  in  1  one returned word (written into FIFO externally)
- frame_done  out  1  one-cycle pulse, whole frame fetched
- frame_err  out  1  one-cycle pulse, vsync arrived before frame complete
- busy  out  1  state ≠ IDLE and ≠ WAIT_VS

Behaviour:
- Reset values: all outputs 0; state IDLE; address FB_BASE; remaining count 0.
- Frame word total: TOTAL = LINE_PIX*FRAME_LINES. Counter width CNT_W = 20.
- Address arithmetic: rd_addr increments modulo 2^ADDR_W.
- vs_rise: vga_vsync registered once; pulse when the registered value is 0 and the current value is 1. Detection latency is one cycle.
- States:
  - IDLE: if rd_en, go to WAIT_VS.
  - WAIT_VS: on vs_rise, go to FLUSH. If rd_en is 0, go to IDLE.
  - FLUSH: one cycle. fifo_clr=1; addr←FB_BASE; remain←TOTAL. Go to CHECK.
  - CHECK:
    - remain==0: go to DONE.
    - else if fifo_lvl < FIFO_LOW: go to REQ, latching rd_len = min(BURST_LEN, remain).
    - else stay.
  - REQ: rd_req=1. rd_addr and rd_len are held stable until rd_ack; rd_req is never withdrawn before ack. On rd_ack, go to DATA; rd_req drops the next cycle.
  - DATA: count rd_vld. When count reaches rd_len: addr+=rd_len; remain-=rd_len; go to CHECK. rd_vld outside DATA is ignored.
  - DONE: frame_done=1 for one cycle. Go to WAIT_VS.
- vs_rise during CHECK: frame_err pulse; go to FLUSH.
- vs_rise during REQ or DATA: frame_err pulse; a restart flag is set. The current request is completed through ack and all data, then the FSM goes to FLUSH instead of CHECK.
- vs_rise coincident with entering DONE: counts as complete. frame_done only, no error; go to FLUSH directly.
- rd_en deasserted:
  - In CHECK: go to IDLE next cycle.
  - In REQ or DATA: the burst completes, then go to IDLE.
  - FLUSH and DONE complete normally before honouring rd_en.
- s_rst mid-burst: immediate return to reset values. The arbiter is required to tolerate a dropped request.

Optional Feature:
- Macro: VGA_RD_DOUBLE_BUF_EN.
- Enabled:
  - Adds parameter FB_BASE2 (default 24'h080000).
  - Adds input wr_buf_done (one-cycle pulse from the writer) and output rd_buf_sel.
  - A pending flag is set by wr_buf_done.
  - At FLUSH, if pending: toggle rd_buf_sel and clear pending. Start address is FB_BASE when rd_buf_sel=0, FB_BASE2 when 1.
  - wr_buf_done coincident with FLUSH applies to the next frame.
- Disabled: always FB_BASE; no extra ports.

Decomposition:
- Package vga_rd_pkg: state enum (IDLE, WAIT_VS, FLUSH, CHECK, REQ, DATA, DONE), CNT_W, burst-length width.
- Sub-module vga_rd_addr_gen: address and remain registers plus min(BURST_LEN, remain) logic, controlled by load/step strobes from the FSM.

Test Plan:
- Test parameters: LINE_PIX=16, FRAME_LINES=2, BURST_LEN=8, FIFO_LOW=4.
- Nominal frame: rd_en=1, vsync rise, fifo_lvl=0, ack after 2 cycles, 8 rd_vld per burst → fifo_clr once; 4 requests at addrs 0,8,16,24; frame_done after the 32nd word.
- Threshold gating: fifo_lvl held at 4 → no rd_req. Drop to 3 → rd_req next cycle.
- Partial burst: LINE_PIX=20, FRAME_LINES=1 → rd_len sequence 8,8,4; addrs 0,8,16.
- Early vsync: vs_rise after 2nd ack, mid-data → frame_err pulse; burst finishes its 8 words; fifo_clr; next rd_addr=0.
- Req hold and disable: rd_ack withheld 10 cycles with rd_en dropped → rd_req and rd_addr stable throughout; after ack and 8 words → IDLE, busy=0.
- Double buffer (macro on): wr_buf_done pulse, then vsync rise → rd_buf_sel=1; first rd_addr=FB_BASE2. No pulse on the next frame → stays at FB_BASE2.
